// File: rtl/seno_rom_arbiter_if.sv
// seno_rom_arbiter_if: CPU, stream and ROM signals between requesters and the sine ROM arbiter
interface seno_rom_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 32
);
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          cpu_stall;
    logic          cpu_valid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_err;
    logic          stream_start;
    logic          stream_stop;
    logic [AW-1:0] stream_base;
    logic [AW-1:0] stream_len;
    logic [AW-1:0] stream_step;
    logic          stream_ready;
    logic          stream_valid;
    logic [DW-1:0] stream_data;
    logic          stream_busy;
    logic [15:0]   stream_count;
    logic [31:0]   rom_addr;
    logic [DW-1:0] rom_rd;

    modport master (
        output cpu_req, cpu_addr, stream_start, stream_stop, stream_base, stream_len,
               stream_step, stream_ready, rom_rd,
        input  cpu_stall, cpu_valid, cpu_rdata, cpu_err, stream_valid, stream_data,
               stream_busy, stream_count, rom_addr
    );

    modport slave (
        input  cpu_req, cpu_addr, stream_start, stream_stop, stream_base, stream_len,
               stream_step, stream_ready, rom_rd,
        output cpu_stall, cpu_valid, cpu_rdata, cpu_err, stream_valid, stream_data,
               stream_busy, stream_count, rom_addr
    );
endinterface

// File: rtl/seno_rom_arbiter.sv
// seno_rom_arbiter: shares the sine ROM between CPU loads and a wrapping sample stream
module seno_rom_arbiter #(
    parameter int DEPTH      = 8100,
    parameter int AW         = 13,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              reset,
    seno_rom_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [AW-1:0] base_q, len_q, step_q, offset;
    logic [SW-1:0] starve_cnt;
    logic          stream_want, stream_grant, cpu_grant, cpu_oob, start_ok;
    logic [AW:0]   sum, stream_addr, next_off;

    // CPU wins unless the stream has been starved long enough; stream address wraps once
    always_comb begin
        stream_want  = (state == RUN) & (~bus.stream_valid | bus.stream_ready);
        stream_grant = stream_want & (~bus.cpu_req | (starve_cnt == SW'(STARVE_MAX)));
        cpu_grant    = bus.cpu_req & ~stream_grant;
        cpu_oob      = bus.cpu_addr >= 32'(DEPTH);
        sum          = {1'b0, base_q} + {1'b0, offset};
        stream_addr  = (sum >= DEPTH_W) ? sum - DEPTH_W : sum;
        next_off     = {1'b0, offset} + {1'b0, step_q};
        start_ok     = (state == IDLE) & bus.stream_start & ~bus.stream_stop & (|bus.stream_len)
                     & ({1'b0, bus.stream_base} < DEPTH_W) & (bus.stream_step < bus.stream_len);
    end

    assign bus.cpu_stall   = bus.cpu_req & ~cpu_grant;
    assign bus.stream_busy = state == RUN;
    assign bus.rom_addr    = cpu_grant ? bus.cpu_addr : stream_grant ? 32'(stream_addr) : 32'd0;

    // CPU response, starvation tracking and stream FSM with its sample register
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            base_q            <= '0;
            len_q             <= '0;
            step_q            <= '0;
            offset            <= '0;
            starve_cnt        <= '0;
            bus.cpu_valid     <= 1'b0;
            bus.cpu_err       <= 1'b0;
            bus.cpu_rdata     <= '0;
            bus.stream_valid  <= 1'b0;
            bus.stream_data   <= '0;
            bus.stream_count  <= '0;
        end else begin
            bus.cpu_valid <= cpu_grant;
            bus.cpu_err   <= cpu_grant & cpu_oob;
            if (cpu_grant)
                bus.cpu_rdata <= cpu_oob ? {DW{1'b0}} : bus.rom_rd;
            if (~stream_want | stream_grant)
                starve_cnt <= '0;
            else if (cpu_grant && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;
            if (start_ok)
                bus.stream_count <= '0;
            else if (bus.stream_valid & bus.stream_ready)
                bus.stream_count <= bus.stream_count + 16'd1;
            if (state == IDLE) begin
                if (start_ok) begin
                    state  <= RUN;
                    base_q <= bus.stream_base;
                    len_q  <= bus.stream_len;
                    step_q <= bus.stream_step;
                    offset <= '0;
                end
            end else if (bus.stream_stop) begin
                state            <= IDLE;
                bus.stream_valid <= 1'b0;
            end else if (stream_grant) begin
                bus.stream_data  <= bus.rom_rd;
                bus.stream_valid <= 1'b1;
                offset <= (next_off >= {1'b0, len_q}) ? AW'(next_off - {1'b0, len_q}) : AW'(next_off);
            end else if (bus.stream_ready) begin
                bus.stream_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seno_rom_arbiter.sv
// tb_seno_rom_arbiter: directed checks of CPU reads, stream wrap, contention, backpressure and stop
module tb_seno_rom_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   seq [5] = '{8098, 0, 2, 8099, 1};
    int   cpu_a [4] = '{0, 1, 8099, 8100};

    seno_rom_arbiter_if #(.AW(13), .DW(32)) bus ();

    seno_rom_arbiter #(.DEPTH(8100), .AW(13), .DW(32), .STARVE_MAX(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a < 32'd8100) ? ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F) : 32'hBAD0_BAD0;
    endfunction

    assign bus.rom_rd = rom(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.cpu_req      = 1'b1;
        bus.cpu_addr     = 32'd5;
        bus.stream_start = 1'b1;
        bus.stream_stop  = 1'b0;
        bus.stream_base  = 13'd0;
        bus.stream_len   = 13'd4;
        bus.stream_step  = 13'd1;
        bus.stream_ready = 1'b1;
        cyc();
        cyc();
        check("rst_cpu_valid", 32'(bus.cpu_valid), 0);
        check("rst_cpu_err", 32'(bus.cpu_err), 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("rst_stream_valid", 32'(bus.stream_valid), 0);
        check("rst_stream_data", bus.stream_data, 0);
        check("rst_busy", 32'(bus.stream_busy), 0);
        check("rst_count", 32'(bus.stream_count), 0);
        reset            = 1'b0;
        bus.cpu_req      = 1'b0;
        bus.stream_start = 1'b0;
        cyc();
        check("post_rst_busy", 32'(bus.stream_busy), 0);
        check("post_rst_cpu_valid", 32'(bus.cpu_valid), 0);

        for (int i = 0; i < 4; i++) begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = cpu_a[i];
            #1;
            check("cpu_stall", 32'(bus.cpu_stall), 0);
            check("cpu_rom_addr", bus.rom_addr, cpu_a[i]);
            cyc();
            check("cpu_valid", 32'(bus.cpu_valid), 1);
            check("cpu_rdata", bus.cpu_rdata, (i == 3) ? 32'd0 : rom(cpu_a[i]));
            check("cpu_err", 32'(bus.cpu_err), (i == 3) ? 32'd1 : 32'd0);
        end
        bus.cpu_req = 1'b0;
        cyc();
        check("cpu_valid_idle", 32'(bus.cpu_valid), 0);

        bus.stream_base  = 13'd8098;
        bus.stream_len   = 13'd5;
        bus.stream_step  = 13'd2;
        bus.stream_ready = 1'b1;
        bus.stream_start = 1'b1;
        cyc();
        bus.stream_start = 1'b0;
        check("start_busy", 32'(bus.stream_busy), 1);
        check("start_valid", 32'(bus.stream_valid), 0);
        #1;
        check("first_rom_addr", bus.rom_addr, 8098);
        cyc();
        for (int k = 0; k < 7; k++) begin
            check("stream_valid", 32'(bus.stream_valid), 1);
            check("stream_data", bus.stream_data, rom(seq[k % 5]));
            check("stream_count", 32'(bus.stream_count), k);
            if (k < 6) cyc();
        end

        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'd100;
        for (int i = 0; i < 15; i++) begin
            #1;
            check("cont_stall", 32'(bus.cpu_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
            check("cont_rom_addr", bus.rom_addr, (i % 5 == 4) ? seq[(7 + i / 5) % 5] : 100);
            cyc();
        end
        check("cont_data", bus.stream_data, rom(seq[9 % 5]));
        check("cont_valid", 32'(bus.stream_valid), 1);

        bus.stream_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_stall", 32'(bus.cpu_stall), 0);
            check("bp_rom_addr", bus.rom_addr, 100);
            cyc();
            check("bp_data", bus.stream_data, rom(seq[9 % 5]));
            check("bp_valid", 32'(bus.stream_valid), 1);
        end
        check("bp_count", 32'(bus.stream_count), 9);
        bus.stream_ready = 1'b1;
        bus.cpu_req      = 1'b0;
        #1;
        check("resume_rom_addr", bus.rom_addr, seq[10 % 5]);
        cyc();
        check("resume_data", bus.stream_data, rom(seq[10 % 5]));
        check("resume_count", 32'(bus.stream_count), 10);
        cyc();
        check("resume_data2", bus.stream_data, rom(seq[11 % 5]));
        check("resume_count2", 32'(bus.stream_count), 11);

        bus.stream_ready = 1'b0;
        cyc();
        check("hold_valid", 32'(bus.stream_valid), 1);
        check("hold_data", bus.stream_data, rom(seq[11 % 5]));
        bus.stream_stop = 1'b1;
        cyc();
        bus.stream_stop = 1'b0;
        check("stop_valid", 32'(bus.stream_valid), 0);
        check("stop_busy", 32'(bus.stream_busy), 0);
        bus.stream_base  = 13'd0;
        bus.stream_len   = 13'd3;
        bus.stream_step  = 13'd3;
        bus.stream_start = 1'b1;
        cyc();
        bus.stream_start = 1'b0;
        check("bad_start_busy", 32'(bus.stream_busy), 0);
        check("bad_start_count", 32'(bus.stream_count), 11);
        cyc();
        check("bad_start_valid", 32'(bus.stream_valid), 0);
        check("idle_rom_addr", bus.rom_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
